// File: rtl/conj_mult_sched.sv
// rtl/conj_mult_sched.sv - conjugate complex multiply y = x[n]*conj(x[n-1]) on one shared multiplier
module conj_mult_sched #(
  parameter int WIDTH     = 16,
  parameter int OUT_SHIFT = WIDTH - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic signed [WIDTH-1:0] real_i,
  input  logic signed [WIDTH-1:0] imag_i,
  output logic signed [WIDTH-1:0] real_o,
  output logic signed [WIDTH-1:0] imag_o,
  output logic                    valid_o,
  output logic                    busy_o
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + 1;
  localparam logic signed [AW-1:0] MAX_V = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_OUT} state_t;

  state_t                  state_q, state_d;
  logic                    primed_q, primed_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic signed [AW-1:0]    acc_q, acc_d, re_acc_q, re_acc_d;
  logic signed [WIDTH-1:0] real_q, real_d, imag_q, imag_d;
  logic                    valid_q, valid_d;
  logic signed [WIDTH-1:0] mul_x, mul_y;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    prod_ext;
  logic                    xfer;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s;
    s = v >>> OUT_SHIFT;
    if (s > MAX_V)      s = MAX_V;
    else if (s < MIN_V) s = MIN_V;
    return s[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      primed_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      acc_q    <= '0;
      re_acc_q <= '0;
      real_q   <= '0;
      imag_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      primed_q <= primed_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      acc_q    <= acc_d;
      re_acc_q <= re_acc_d;
      real_q   <= real_d;
      imag_q   <= imag_d;
      valid_q  <= valid_d;
    end
  end

  assign xfer = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_WAIT;
      S_WAIT: begin
        if (!start_i)            state_d = S_IDLE;
        else if (xfer && primed_q) state_d = S_MUL0;
      end
      S_MUL0: state_d = S_MUL1;
      S_MUL1: state_d = S_MUL2;
      S_MUL2: state_d = S_MUL3;
      S_MUL3: state_d = S_OUT;
      S_OUT: begin
        if (xfer)         state_d = S_MUL0;
        else if (start_i) state_d = S_WAIT;
        else              state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = ((state_q == S_WAIT) || (state_q == S_OUT)) && start_i;
    busy_o  = (state_q == S_MUL0) || (state_q == S_MUL1) || (state_q == S_MUL2) ||
              (state_q == S_MUL3) || (state_q == S_OUT);
    real_o  = real_q;
    imag_o  = imag_q;
    valid_o = valid_q;
  end

  // Operand select for the shared multiplier: a*c, b*d, b*c, a*d in MUL0..MUL3.
  always_comb begin
    mul_x = a_q;
    mul_y = c_q;
    case (state_q)
      S_MUL1:  begin mul_x = b_q; mul_y = d_q; end
      S_MUL2:  begin mul_x = b_q; mul_y = c_q; end
      S_MUL3:  begin mul_x = a_q; mul_y = d_q; end
      default: begin mul_x = a_q; mul_y = c_q; end
    endcase
    prod     = mul_x * mul_y;
    prod_ext = {prod[PW-1], prod};
  end

  always_comb begin
    primed_d = primed_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    acc_d    = acc_q;
    re_acc_d = re_acc_q;
    real_d   = real_q;
    imag_d   = imag_q;
    valid_d  = 1'b0;
    if (xfer) begin
      if (primed_q) begin
        a_d = real_i;
        b_d = imag_i;
      end else begin
        c_d      = real_i;
        d_d      = imag_i;
        primed_d = 1'b1;
      end
    end
    case (state_q)
      S_WAIT: if (!start_i) primed_d = 1'b0;
      S_MUL0: acc_d = prod_ext;
      S_MUL1: acc_d = acc_q + prod_ext;
      S_MUL2: begin
        acc_d    = prod_ext;
        re_acc_d = acc_q;
      end
      S_MUL3: begin
        acc_d = acc_q - prod_ext;
        c_d   = a_q;
        d_d   = b_q;
      end
      S_OUT: begin
        real_d  = sat(re_acc_q);
        imag_d  = sat(acc_q);
        valid_d = 1'b1;
        if (!xfer && !start_i) primed_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conj_mult_sched.sv
// tb/tb_conj_mult_sched.sv - scoreboard bench for conj_mult_sched against a complex-arithmetic model
module tb_conj_mult_sched;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start_i = 1'b0;
  logic               valid_i = 1'b0;
  logic signed [15:0] real_i = '0;
  logic signed [15:0] imag_i = '0;
  logic               ready_o, valid_o, busy_o;
  logic signed [15:0] real_o, imag_o;

  conj_mult_sched #(.WIDTH(16), .OUT_SHIFT(15)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i), .ready_o(ready_o),
    .real_i(real_i), .imag_i(imag_i), .real_o(real_o), .imag_o(imag_o),
    .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int re; int im; int t;} exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  bit   primed_m = 1'b0;
  int   prev_re_m = 0, prev_im_m = 0;
  int   xfer_t[$];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sat_shift(input longint v);
    longint s;
    s = v >>> 15;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  // y = (a+jb)*(c-jd) = (ac+bd) + j(bc-ad)
  task automatic model_xfer(input int a, input int b, input int t);
    exp_t e;
    xfer_t.push_back(t);
    if (primed_m) begin
      e.re = sat_shift(longint'(a) * prev_re_m + longint'(b) * prev_im_m);
      e.im = sat_shift(longint'(b) * prev_re_m - longint'(a) * prev_im_m);
      e.t  = t;
      q.push_back(e);
    end
    primed_m  = 1'b1;
    prev_re_m = a;
    prev_im_m = b;
  endtask

  always @(negedge clk) begin
    if (rst && valid_o) begin
      pulses++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got real=%0d imag=%0d, no result expected", real_o, imag_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("real_o", real_o, e.re);
        chk("imag_o", imag_o, e.im);
        chk("latency_cycle", cyc, e.t + 5);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge with valid_i still high.
  task automatic send(input int re, input int im);
    int n;
    valid_i = 1'b1;
    real_i  = 16'(re);
    imag_i  = 16'(im);
    #1;
    n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: ready_o stayed %0d, required 1", ready_o);
    end else begin
      model_xfer(re, im, cyc + 1);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  function automatic int rnd_sample();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return -32768;
    if (sel == 1) return 32767;
    return int'($signed(16'($urandom)));
  endfunction

  initial begin
    int p0, gap;
    repeat (2) @(negedge clk);
    chk("reset_real_o", real_o, 0);
    chk("reset_imag_o", imag_o, 0);
    chk("reset_valid_o", valid_o, 0);
    chk("reset_ready_o", ready_o, 0);
    chk("reset_busy_o", busy_o, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready_o", ready_o, 0);
    start_i = 1'b1;

    send(16384, 0);
    send(16384, 0);
    valid_i = 1'b0;
    drain();

    send(0, 16384);
    send(-16384, 0);
    valid_i = 1'b0;
    drain();

    send(-32768, -32768);
    send(-32768, -32768);
    valid_i = 1'b0;
    drain();

    send(100, 200);
    valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mul2_busy_o", busy_o, 1);
    rst = 1'b0;
    #1;
    chk("abort_real_o", real_o, 0);
    chk("abort_imag_o", imag_o, 0);
    chk("abort_valid_o", valid_o, 0);
    chk("abort_ready_o", ready_o, 0);
    chk("abort_busy_o", busy_o, 0);
    q.delete();
    primed_m = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    xfer_t.delete();
    p0 = pulses;
    for (int i = 0; i < 10; i++) send(rnd_sample(), rnd_sample());
    valid_i = 1'b0;
    drain();
    chk("b2b_pulses", pulses - p0, 9);
    chk("b2b_prime_gap", xfer_t[1] - xfer_t[0], 1);
    for (int i = 2; i < 10; i++) chk("b2b_spacing", xfer_t[i] - xfer_t[i-1], 5);

    send(3000, 4000);
    valid_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    drain();
    primed_m = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop_ready_o", ready_o, 0);
    chk("drop_busy_o", busy_o, 0);
    start_i = 1'b1;
    p0 = pulses;
    send(5, 6);
    valid_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("reprime_no_output", pulses - p0, 0);
    send(-7000, 8000);
    valid_i = 1'b0;
    drain();

    for (int i = 0; i < 40; i++) begin
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        valid_i = 1'b0;
        repeat (gap) @(negedge clk);
      end
      if ($urandom_range(0, 7) == 0) begin
        valid_i = 1'b0;
        start_i = 1'b0;
        repeat (8) @(negedge clk);
        primed_m = 1'b0;
        start_i = 1'b1;
      end
      send(rnd_sample(), rnd_sample());
    end
    valid_i = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
